// File: rtl/dma_tx_buf_if.sv
// Handshake bundle for dma_tx_buf: demux-facing write stream plus AXI-stream replay output.
// The slave modport is the buffer's view; master is the environment driving it.
interface dma_tx_buf_if;
    logic        dma_axi_trdy;
    logic        dma_axi_tvld;
    logic [63:0] dma_axi_tdat;
    logic        dma_ram_rdy;
    logic        m_axis_tvld;
    logic        m_axis_trdy;
    logic [63:0] m_axis_tdat;
    logic        m_axis_tlast;

    modport slave (
        output dma_axi_trdy,
        input  dma_axi_tvld,
        input  dma_axi_tdat,
        output dma_ram_rdy,
        output m_axis_tvld,
        input  m_axis_trdy,
        output m_axis_tdat,
        output m_axis_tlast
    );

    modport master (
        input  dma_axi_trdy,
        output dma_axi_tvld,
        output dma_axi_tdat,
        input  dma_ram_rdy,
        input  m_axis_tvld,
        output m_axis_trdy,
        input  m_axis_tdat,
        input  m_axis_tlast
    );
endinterface

// File: rtl/dma_tx_buf.sv
// Per-destination landing buffer: stores one DEPTH-word frame from the demux, then
// replays it NREP times on an AXI-stream output with tlast at the end of every pass.
module dma_tx_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH),
    parameter int NREP  = 1
) (
    input  logic         clk_dma,
    input  logic         srstn,
    dma_tx_buf_if.slave  bus
);

    localparam logic [0:0]    ST_FILL   = 1'b0;
    localparam logic [0:0]    ST_DRAIN  = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [7:0]    REP_END   = 8'(NREP);

    logic [0:0]    r_state;
    logic [AW-1:0] r_wrAddr;
    logic [AW-1:0] r_rdAddr;
    logic [7:0]    r_repCnt;
    logic [63:0]   r_mem [DEPTH];
    logic [63:0]   r_rdData;
    logic          r_rdValid;
    logic          r_rdLast;
    logic [63:0]   r_fifoDat [2];
    logic          r_fifoLast [2];
    logic          r_fifoWrPtr;
    logic          r_fifoRdPtr;
    logic [1:0]    r_fifoCnt;

    logic          w_trdy;
    logic          w_wrEn;
    logic          w_rdIssue;
    logic          w_fifoEmpty;
    logic          w_outValid;
    logic [63:0]   w_outDat;
    logic          w_outLast;
    logic          w_pop;
    logic          w_popFifo;
    logic          w_push;
    logic          w_drainDone;

    // Ready is forced low while srstn is held so nothing lands during reset.
    assign w_trdy      = srstn & (r_state == ST_FILL);
    assign w_wrEn      = w_trdy & bus.dma_axi_tvld;

    // The RAM output register bypasses the FIFO when it is empty, giving first data at T+2.
    assign w_fifoEmpty = (r_fifoCnt == 2'd0);
    assign w_outValid  = !w_fifoEmpty || r_rdValid;
    assign w_outDat    = w_fifoEmpty ? r_rdData : r_fifoDat[r_fifoRdPtr];
    assign w_outLast   = w_fifoEmpty ? r_rdLast : r_fifoLast[r_fifoRdPtr];
    assign w_pop       = w_outValid & bus.m_axis_trdy;
    assign w_popFifo   = w_pop & !w_fifoEmpty;
    assign w_push      = r_rdValid & !(w_fifoEmpty & w_pop);

    assign w_rdIssue   = (r_state == ST_DRAIN)
                       && (({1'b0, r_fifoCnt} + {2'b00, r_rdValid}) < 3'd2)
                       && (r_repCnt < REP_END);
    // Only the final pass's last word can pop once every pass has been issued.
    assign w_drainDone = w_pop & w_outLast & (r_repCnt == REP_END);

    assign bus.dma_axi_trdy = w_trdy;
    assign bus.dma_ram_rdy  = (r_state == ST_DRAIN);
    assign bus.m_axis_tvld  = w_outValid;
    assign bus.m_axis_tdat  = w_outDat;
    assign bus.m_axis_tlast = w_outLast;

    always_ff @(posedge clk_dma) begin
        if (w_wrEn) begin
            r_mem[r_wrAddr] <= bus.dma_axi_tdat;
        end
    end

    always_ff @(posedge clk_dma) begin
        if (!srstn) begin
            r_rdData <= '0;
        end else if (w_rdIssue) begin
            r_rdData <= r_mem[r_rdAddr];
        end
    end

    always_ff @(posedge clk_dma) begin
        if (!srstn) begin
            r_state     <= ST_FILL;
            r_wrAddr    <= '0;
            r_rdAddr    <= '0;
            r_repCnt    <= '0;
            r_rdValid   <= 1'b0;
            r_rdLast    <= 1'b0;
            r_fifoDat   <= '{default: '0};
            r_fifoLast  <= '{default: 1'b0};
            r_fifoWrPtr <= 1'b0;
            r_fifoRdPtr <= 1'b0;
            r_fifoCnt   <= 2'd0;
        end else begin
            if (w_wrEn) begin
                r_wrAddr <= r_wrAddr + AW'(1);
                if (r_wrAddr == LAST_ADDR) begin
                    r_state <= ST_DRAIN;
                end
            end

            r_rdValid <= w_rdIssue;
            if (w_rdIssue) begin
                r_rdLast <= (r_rdAddr == LAST_ADDR);
                r_rdAddr <= r_rdAddr + AW'(1);
                if (r_rdAddr == LAST_ADDR) begin
                    r_repCnt <= r_repCnt + 8'd1;
                end
            end

            if (w_push) begin
                r_fifoDat[r_fifoWrPtr]  <= r_rdData;
                r_fifoLast[r_fifoWrPtr] <= r_rdLast;
                r_fifoWrPtr             <= ~r_fifoWrPtr;
            end
            if (w_popFifo) begin
                r_fifoRdPtr <= ~r_fifoRdPtr;
            end
            r_fifoCnt <= r_fifoCnt + {1'b0, w_push} - {1'b0, w_popFifo};

            if (w_drainDone) begin
                r_state  <= ST_FILL;
                r_wrAddr <= '0;
                r_rdAddr <= '0;
                r_repCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dma_tx_buf.sv
// Self-checking bench for dma_tx_buf: NREP=1 and NREP=3 instances share one input stream,
// each tracked by a frame/queue-level model checked every cycle on the falling edge.
module tb_dma_tx_buf;

    localparam int DEPTH = 256;

    logic        clk_dma  = 1'b0;
    logic        srstn    = 1'b0;
    logic        inTvld   = 1'b0;
    logic [63:0] inTdat   = '0;
    logic        outReady = 1'b1;
    bit          randReady = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk_dma = ~clk_dma;

    dma_tx_buf_if bus1 ();
    dma_tx_buf_if bus3 ();

    assign bus1.dma_axi_tvld = inTvld;
    assign bus1.dma_axi_tdat = inTdat;
    assign bus1.m_axis_trdy  = outReady;
    assign bus3.dma_axi_tvld = inTvld;
    assign bus3.dma_axi_tdat = inTdat;
    assign bus3.m_axis_trdy  = outReady;

    dma_tx_buf #(.DEPTH(DEPTH), .AW(8), .NREP(1)) dut1 (
        .clk_dma (clk_dma),
        .srstn   (srstn),
        .bus     (bus1)
    );

    dma_tx_buf #(.DEPTH(DEPTH), .AW(8), .NREP(3)) dut3 (
        .clk_dma (clk_dma),
        .srstn   (srstn),
        .bus     (bus3)
    );

    // Model state: index 0 is the NREP=1 instance, index 1 the NREP=3 instance.
    bit          draining [2];
    int          fillCnt [2];
    int          drainCycle [2];
    int          outIdx [2];
    logic [63:0] frame [2][DEPTH];
    bit          rstApplied = 1'b0;

    int          xferCnt [2];
    int          lastCnt [2];
    int          hsCnt [2];
    logic [63:0] firstWord [2];
    logic [63:0] lastWord [2];
    int          tCyc [2];
    int          rdyRiseCyc [2];
    int          tvldFirstCyc [2];
    int          uCyc [2];
    int          trdyBackCyc [2];
    bit          prevRdy [2];
    bit          prevTrdy [2];
    bit          seenTvld [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input int k, input int nrep, input logic trdy, input logic tvld,
                               input logic [63:0] tdat, input logic tlast, input logic rdy);
        string tag;
        tag = $sformatf("inst%0d", k);
        if (rstApplied) begin
            check({tag, ".rst.tvld"},  64'(tvld),  64'd0);
            check({tag, ".rst.tdat"},  tdat,       64'd0);
            check({tag, ".rst.tlast"}, 64'(tlast), 64'd0);
            check({tag, ".rst.rdy"},   64'(rdy),   64'd0);
        end
        if (!srstn) begin
            check({tag, ".rst.trdy"}, 64'(trdy), 64'd0);
            draining[k]   = 1'b0;
            fillCnt[k]    = 0;
            outIdx[k]     = 0;
            drainCycle[k] = 0;
            prevRdy[k]    = 1'b0;
            prevTrdy[k]   = 1'b0;
            return;
        end

        check({tag, ".trdy"}, 64'(trdy), 64'(!draining[k]));
        check({tag, ".rdy"},  64'(rdy),  64'(draining[k]));
        if (rdy === 1'b1 && !prevRdy[k]) rdyRiseCyc[k] = cyc;
        if (trdy === 1'b1 && !prevTrdy[k]) trdyBackCyc[k] = cyc;
        prevRdy[k]  = (rdy === 1'b1);
        prevTrdy[k] = (trdy === 1'b1);

        if (!draining[k]) begin
            check({tag, ".idleTvld"}, 64'(tvld), 64'd0);
            if (inTvld) begin
                frame[k][fillCnt[k]] = inTdat;
                fillCnt[k]++;
                hsCnt[k]++;
                if (fillCnt[k] == DEPTH) begin
                    draining[k]   = 1'b1;
                    drainCycle[k] = 0;
                    outIdx[k]     = 0;
                    fillCnt[k]    = 0;
                    tCyc[k]       = cyc;
                    seenTvld[k]   = 1'b0;
                end
            end
        end else begin
            if (drainCycle[k] >= 1) begin
                check({tag, ".noBubble"}, 64'(tvld), 64'd1);
            end
            if (tvld === 1'b1) begin
                check({tag, ".tdat"},  tdat,       frame[k][outIdx[k] % DEPTH]);
                check({tag, ".tlast"}, 64'(tlast), 64'((outIdx[k] % DEPTH) == DEPTH - 1));
                if (!seenTvld[k]) begin
                    seenTvld[k]     = 1'b1;
                    tvldFirstCyc[k] = cyc;
                end
            end
            drainCycle[k]++;
            if (tvld === 1'b1 && outReady) begin
                if (xferCnt[k] == 0) firstWord[k] = tdat;
                lastWord[k] = tdat;
                xferCnt[k]++;
                if (tlast === 1'b1) lastCnt[k]++;
                outIdx[k]++;
                if (outIdx[k] == nrep * DEPTH) begin
                    draining[k] = 1'b0;
                    uCyc[k]     = cyc;
                end
            end
        end
    endtask

    always @(negedge clk_dma) begin
        cyc++;
        checkOutput(0, 1, bus1.dma_axi_trdy, bus1.m_axis_tvld, bus1.m_axis_tdat,
                    bus1.m_axis_tlast, bus1.dma_ram_rdy);
        checkOutput(1, 3, bus3.dma_axi_trdy, bus3.m_axis_tvld, bus3.m_axis_tdat,
                    bus3.m_axis_tlast, bus3.dma_ram_rdy);
        rstApplied = !srstn;
    end

    always @(posedge clk_dma) begin
        #1;
        outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Data advances per accepted word on instance 1, or per cycle for the overrun pattern.
    task automatic applyStimulus(input logic [63:0] base, input int maxWords, input int maxCycles,
                                 input bit gaps, input bit perCycle);
        int words = 0;
        int c = 0;
        while (words < maxWords && c < maxCycles) begin
            @(posedge clk_dma);
            #1;
            inTvld = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            inTdat = perCycle ? base + 64'(c) : base + 64'(words);
            @(negedge clk_dma);
            if (inTvld && bus1.dma_axi_trdy) words++;
            c++;
        end
        @(posedge clk_dma);
        #1;
        inTvld = 1'b0;
        if (!perCycle) checkInt("fillWords", words, maxWords);
    endtask

    task automatic waitDrained(input int budget);
        int c = 0;
        while ((draining[0] || draining[1]) && c < budget) begin
            @(posedge clk_dma);
            c++;
        end
        checkInt("drainTimeout", int'(draining[0] || draining[1]), 0);
        repeat (3) @(posedge clk_dma);
    endtask

    task automatic resetStats();
        for (int k = 0; k < 2; k++) begin
            xferCnt[k]   = 0;
            lastCnt[k]   = 0;
            hsCnt[k]     = 0;
            firstWord[k] = '0;
            lastWord[k]  = '0;
        end
    endtask

    initial begin
        resetStats();
        repeat (3) @(posedge clk_dma);
        #1;
        srstn = 1'b1;
        repeat (2) @(posedge clk_dma);

        $display("[TB] frame 0..255, ready held high");
        applyStimulus(64'h0, 256, 1000, 1'b0, 1'b0);
        waitDrained(3000);
        checkInt("t1.rdyLatency",   rdyRiseCyc[0] - tCyc[0], 1);
        checkInt("t1.tvldLatency",  tvldFirstCyc[0] - tCyc[0], 2);
        checkInt("t1.trdyLatency",  trdyBackCyc[0] - uCyc[0], 1);
        checkInt("t1.inWords",      hsCnt[0], 256);
        checkInt("t1.xfers",        xferCnt[0], 256);
        checkInt("t1.tlasts",       lastCnt[0], 1);
        check("t1.firstWord",       firstWord[0], 64'd0);
        check("t1.lastWord",        lastWord[0], 64'd255);
        checkInt("t1.rep3.xfers",   xferCnt[1], 768);
        checkInt("t1.rep3.tlasts",  lastCnt[1], 3);
        check("t1.rep3.lastWord",   lastWord[1], 64'd255);

        $display("[TB] frame 0..255, random output ready");
        resetStats();
        randReady = 1'b1;
        applyStimulus(64'h0, 256, 1000, 1'b0, 1'b0);
        waitDrained(8000);
        randReady = 1'b0;
        checkInt("t2.xfers",  xferCnt[0], 256);
        checkInt("t2.tlasts", lastCnt[0], 1);
        check("t2.lastWord",  lastWord[0], 64'd255);
        checkInt("t2.rep3.xfers", xferCnt[1], 768);

        $display("[TB] overrun, valid held 260 cycles");
        resetStats();
        applyStimulus(64'h1000, 100000, 260, 1'b0, 1'b1);
        waitDrained(3000);
        checkInt("t3.inWords", hsCnt[0], 256);
        checkInt("t3.xfers",   xferCnt[0], 256);
        check("t3.firstWord",  firstWord[0], 64'h1000);
        check("t3.lastWord",   lastWord[0], 64'h10FF);

        $display("[TB] gapped frame A then back-to-back frame B");
        resetStats();
        applyStimulus(64'h2000, 256, 2000, 1'b1, 1'b0);
        applyStimulus(64'h3000, 256, 3000, 1'b0, 1'b0);
        waitDrained(3000);
        checkInt("t4.xfers",       xferCnt[0], 512);
        checkInt("t4.tlasts",      lastCnt[0], 2);
        check("t4.firstWord",      firstWord[0], 64'h2000);
        check("t4.lastWord",       lastWord[0], 64'h30FF);
        checkInt("t4.trdyLatency", trdyBackCyc[0] - uCyc[0], 1);

        $display("[TB] reset pulse mid-drain, then fresh frame");
        resetStats();
        applyStimulus(64'h5000, 256, 1000, 1'b0, 1'b0);
        repeat (100) @(posedge clk_dma);
        #1;
        srstn = 1'b0;
        @(posedge clk_dma);
        #1;
        srstn = 1'b1;
        repeat (6) @(posedge clk_dma);
        resetStats();
        applyStimulus(64'hAA00, 256, 1000, 1'b0, 1'b0);
        waitDrained(3000);
        checkInt("t5.xfers",      xferCnt[0], 256);
        check("t5.firstWord",     firstWord[0], 64'hAA00);
        check("t5.lastWord",      lastWord[0], 64'hAAFF);
        checkInt("t5.rep3.xfers", xferCnt[1], 768);
        check("t5.rep3.firstWord", firstWord[1], 64'hAA00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
